// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus the issue valid/ready port.
// master = fetch unit, slave = memory/datapath side.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [7:0]          imem_rdata;
    logic                instr_valid;
    logic [7:0]          instr;
    logic [1:0]          op;
    logic [PC_WIDTH-1:0] pc_out;
    logic                instr_ready;
    logic                branch_taken;
    logic                halt;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, pc_out,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, pc_out,
        output imem_ack, imem_rdata, instr_ready, branch_taken, halt
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: owns the PC, fetches over req/ack, issues over valid/ready.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer for back-to-back issue.
module instr_fetch #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
`ifdef FETCH_PREFETCH_EN
    localparam bit PrefetchEn = 1'b1;
`else
    localparam bit PrefetchEn = 1'b0;
`endif
    localparam logic [1:0] OpBranch = 2'b11;

    typedef enum logic [1:0] {FETCH, HOLD, STALL} state_e;
    typedef logic [PC_WIDTH-1:0] pc_t;

    state_e     state_q, state_d;
    logic       req_q, req_d;
    logic       valid_q, valid_d;
    logic       buf_valid_q, buf_valid_d;
    pc_t        addr_q, addr_d;
    pc_t        pc_q, pc_d;
    pc_t        buf_pc_q, buf_pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] buf_instr_q, buf_instr_d;
    logic       ack_ok, accept, taken;
    pc_t        imm_sext, next_pc;

    // A following fetch is only started speculatively past a non-branch.
    function automatic logic can_prefetch(input logic [7:0] ins, input logic halt_now);
        return PrefetchEn && (ins[7:6] != OpBranch) && !halt_now;
    endfunction

    assign ack_ok   = req_q & bus.imem_ack;
    assign accept   = valid_q & bus.instr_ready;
    assign taken    = (instr_q[7:6] == OpBranch) & bus.branch_taken;
    assign imm_sext = {{(PC_WIDTH-2){instr_q[1]}}, instr_q[1:0]};
    assign next_pc  = pc_q + pc_t'(1) + (taken ? imm_sext : pc_t'(0));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    req_d = !bus.halt;
                end else if (ack_ok) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = addr_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                    req_d   = can_prefetch(bus.imem_rdata, bus.halt);
                    if (req_d) addr_d = addr_q + pc_t'(1);
                end
            end

            HOLD: begin
                if (accept) begin
                    if (ack_ok) begin
                        // Prefetch returns on the accept edge: bypass the buffer.
                        instr_d = bus.imem_rdata;
                        pc_d    = addr_q;
                        req_d   = can_prefetch(bus.imem_rdata, bus.halt);
                        if (req_d) addr_d = addr_q + pc_t'(1);
                    end else if (buf_valid_q) begin
                        instr_d     = buf_instr_q;
                        pc_d        = buf_pc_q;
                        buf_valid_d = 1'b0;
                        req_d       = can_prefetch(buf_instr_q, bus.halt);
                        if (req_d) addr_d = buf_pc_q + pc_t'(1);
                    end else if (req_q) begin
                        // Prefetch still in flight already targets pc_out+1.
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end else begin
                        valid_d = 1'b0;
                        addr_d  = next_pc;
                        if (bus.halt) begin
                            state_d = STALL;
                        end else begin
                            state_d = FETCH;
                            req_d   = 1'b1;
                        end
                    end
                end else if (ack_ok) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = bus.imem_rdata;
                    buf_pc_d    = addr_q;
                    req_d       = 1'b0;
                end else if (!req_q && !buf_valid_q && can_prefetch(instr_q, bus.halt)) begin
                    req_d  = 1'b1;
                    addr_d = pc_q + pc_t'(1);
                end
            end

            STALL: begin
                if (!bus.halt) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            valid_q     <= 1'b0;
            instr_q     <= 8'h00;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= 8'h00;
            buf_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[7:6];
    assign bus.pc_out      = pc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model + issue scoreboard, table-driven
// branch/next-PC vectors and hand-written ready-stall, halt, wrap and reset sequences.
module tb_instr_fetch;
    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
        logic       taken;
        logic [7:0] next;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    instr_fetch_if #(.PC_WIDTH(8)) bus ();
    instr_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mem [256];
    int         lat = 1;
    int         cnt = 0;
    bit         spurious = 1'b0;
    logic [7:0] data_q [$];
    logic [7:0] model_pc;
    logic       prev_ack, prev_hold;
    logic [7:0] prev_instr, prev_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder and issue monitor, both evaluated on the falling edge.
    always @(negedge clk) begin
        logic       real_ack, acc;
        logic [7:0] exp_i, step_v, exp_addr;
        if (!reset) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 8'h00;
            cnt            = 0;
            data_q.delete();
            model_pc       = 8'h00;
            prev_ack       = 1'b0;
            prev_hold      = 1'b0;
        end else begin
            if (prev_ack) check("valid_after_ack", bus.instr_valid, 1);
            if (prev_hold) begin
                check("hold_instr", bus.instr, prev_instr);
                check("hold_pc", bus.pc_out, prev_pc);
            end
`ifndef FETCH_PREFETCH_EN
            if (bus.instr_valid) check("no_req_in_hold", bus.imem_req, 0);
`endif
            real_ack = 1'b0;
            if (spurious) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 8'hFF;
            end else if (bus.imem_req && cnt >= lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem[bus.imem_addr];
                cnt            = 0;
                real_ack       = 1'b1;
            end else begin
                bus.imem_ack = 1'b0;
                cnt = bus.imem_req ? cnt + 1 : 0;
            end
            if (real_ack) begin
                exp_addr = bus.instr_valid ? model_pc + 8'd1 : model_pc;
                check("fetch_addr", bus.imem_addr, exp_addr);
                data_q.push_back(mem[bus.imem_addr]);
            end
            acc = bus.instr_valid && bus.instr_ready;
            if (acc) begin
                if (data_q.size() == 0) begin
                    check("scoreboard_size", data_q.size(), 1);
                end else begin
                    exp_i = data_q.pop_front();
                    check("issue_instr", bus.instr, exp_i);
                    check("issue_op", bus.op, exp_i[7:6]);
                    check("issue_pc", bus.pc_out, model_pc);
                    step_v = 8'd1;
                    if (exp_i[7:6] == 2'b11 && bus.branch_taken)
                        step_v = 8'd1 + {{6{exp_i[1]}}, exp_i[1:0]};
                    model_pc = model_pc + step_v;
                end
            end
            prev_ack   = real_ack;
            prev_hold  = bus.instr_valid && !acc;
            prev_instr = bus.instr;
            prev_pc    = bus.pc_out;
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_timeout"}, bus.instr_valid, 1);
    endtask

`ifndef FETCH_PREFETCH_EN
    // Issue one instruction at v.pc and check the fetch that follows its acceptance.
    task automatic step(input vec_t v);
        mem[v.pc] = v.instr;
        wait_valid("step");
        check("step_pc", bus.pc_out, v.pc);
        check("step_instr", bus.instr, v.instr);
        @(posedge clk); #1 bus.instr_ready = 1'b1; bus.branch_taken = v.taken;
        @(posedge clk); #1 bus.instr_ready = 1'b0; bus.branch_taken = ~v.taken;
        @(negedge clk);
        check("next_req", bus.imem_req, 1);
        check("next_addr", bus.imem_addr, v.next);
    endtask
`endif

    initial begin
        vec_t vec [8];
        vec_t v;
        int   rises;
        logic prev_req;
        logic [7:0] pc8;
        vec[0] = '{8'h00, 8'h12, 1'b1, 8'h01};
        vec[1] = '{8'h01, 8'hC1, 1'b1, 8'h03};
        vec[2] = '{8'h03, 8'hC3, 1'b0, 8'h04};
        vec[3] = '{8'h04, 8'hC2, 1'b1, 8'h03};
        vec[4] = '{8'h03, 8'h80, 1'b1, 8'h04};
        vec[5] = '{8'h04, 8'h7F, 1'b1, 8'h05};
        vec[6] = '{8'h05, 8'hC0, 1'b1, 8'h06};
        vec[7] = '{8'h06, 8'hC1, 1'b0, 8'h07};

        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.halt         = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 8'h00);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 8'h00);
        check("rst_op", bus.op, 2'b00);
        check("rst_pc", bus.pc_out, 8'h00);

`ifdef FETCH_PREFETCH_EN
        lat = 0;
        for (int i = 0; i < 256; i++) mem[i] = {2'b00, 6'(i)};
        mem[6] = 8'hC1;
        @(posedge clk); #1 reset = 1'b1; bus.instr_ready = 1'b1;
        wait_valid("pf");
        for (int k = 0; k < 6; k++) begin
            check("pf_valid", bus.instr_valid, 1);
            check("pf_pc", bus.pc_out, k);
            if (k < 5) @(negedge clk);
        end
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        @(negedge clk);
        check("pf_branch_pc", bus.pc_out, 8'h06);
        for (int k = 0; k < 3; k++) begin
            check("pf_no_req_past_branch", bus.imem_req, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.instr_ready = 1'b1; bus.branch_taken = 1'b0;
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        @(negedge clk);
        check("pf_after_branch_req", bus.imem_req, 1);
        check("pf_after_branch_addr", bus.imem_addr, 8'h07);
`else
        mem[0] = vec[0].instr;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("req_not_before_edge", bus.imem_req, 0);
        @(negedge clk);
        check("req_first_edge", bus.imem_req, 1);
        check("req_first_addr", bus.imem_addr, 8'h00);

        for (int i = 0; i < 8; i++) step(vec[i]);

        // Ready held low: outputs frozen, then exactly one new request.
        mem[7] = 8'h25;
        mem[8] = 8'h4A;
        mem[9] = 8'h9B;
        wait_valid("rdy");
        repeat (5) @(negedge clk);
        check("rdy_req_low", bus.imem_req, 0);
        check("rdy_pc", bus.pc_out, 8'h07);
        @(posedge clk); #1 bus.instr_ready = 1'b1;
        @(posedge clk); #1 bus.instr_ready = 1'b0;
        rises = 0;
        prev_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.imem_req && !prev_req) begin
                rises++;
                check("rdy_req_addr", bus.imem_addr, 8'h08);
            end
            prev_req = bus.imem_req;
        end
        check("rdy_one_request", rises, 1);

        // Halt raised while the fetch of 09 is outstanding.
        @(posedge clk); #1 bus.instr_ready = 1'b1;
        @(posedge clk); #1 bus.instr_ready = 1'b0; bus.halt = 1'b1;
        wait_valid("halt");
        check("halt_issue_pc", bus.pc_out, 8'h09);
        @(posedge clk); #1 bus.instr_ready = 1'b1;
        @(posedge clk); #1 bus.instr_ready = 1'b0; spurious = 1'b1;
        @(posedge clk); #1 spurious = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halt_req_low", bus.imem_req, 0);
            check("halt_valid_low", bus.instr_valid, 0);
        end
        @(posedge clk); #1 bus.halt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resume_req", bus.imem_req, 1);
        check("resume_addr", bus.imem_addr, 8'h0A);

        // Sequential walk through 8'h10 branch and the 8'hFF wrap.
        for (int p = 10; p < 256; p++) begin
            pc8 = 8'(p);
            if (p == 16) begin
                step('{8'h10, 8'hC3, 1'b1, 8'h10});
                step('{8'h10, 8'hC3, 1'b0, 8'h11});
            end else begin
                v.pc    = pc8;
                v.instr = {(pc8[1:0] == 2'b11) ? 2'b10 : pc8[1:0], pc8[5:0]};
                v.taken = 1'b1;
                v.next  = pc8 + 8'd1;
                step(v);
            end
        end

        // Ready always high: scoreboard follows the free-running stream.
        bus.instr_ready = 1'b1;
        repeat (30) @(negedge clk);
        rises = 0;
        while (!bus.imem_req && rises < 10) begin
            @(negedge clk);
            rises++;
        end
        check("stream_req_seen", bus.imem_req, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_req", bus.imem_req, 0);
        check("midrst_addr", bus.imem_addr, 8'h00);
        check("midrst_valid", bus.instr_valid, 0);
        check("midrst_instr", bus.instr, 8'h00);
        check("midrst_pc", bus.pc_out, 8'h00);
        bus.instr_ready = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("postrst_req", bus.imem_req, 1);
        check("postrst_addr", bus.imem_addr, 8'h00);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
